adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_adder_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for one shared IEEE-754 adder.
// Ports: req*/res* requester handshakes, add_* adder handshakes, busy/grant status.
module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_stb,
  output logic             req0_ack,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_stb,
  output logic             req1_ack,
  output logic [WIDTH-1:0] res0_z,
  output logic             res0_stb,
  input  logic             res0_ack,
  output logic [WIDTH-1:0] res1_z,
  output logic             res1_stb,
  input  logic             res1_ack,
  output logic [WIDTH-1:0] add_a,
  output logic             add_a_stb,
  input  logic             add_a_ack,
  output logic [WIDTH-1:0] add_b,
  output logic             add_b_stb,
  input  logic             add_b_ack,
  input  logic [WIDTH-1:0] add_z,
  input  logic             add_z_stb,
  output logic             add_z_ack,
  output logic             busy,
  output logic             grant
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    SEND_A,
    SEND_B,
    WAIT_Z,
    RETURN
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             grant_q, grant_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       rstb_q, rstb_d;
  logic [WIDTH-1:0] res0_q, res0_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] addb_q, addb_d;
  logic             astb_q, astb_d;
  logic             bstb_q, bstb_d;
  logic             zack_q, zack_d;

  logic             winner;
  logic             stb_g;
  logic             rack_g;
  logic [WIDTH-1:0] a_g;
  logic [WIDTH-1:0] b_g;

  // Sole requester wins; on a tie the prio holder wins.
  assign winner = (req0_stb & req1_stb) ? prio_q : req1_stb;

  assign stb_g  = grant_q ? req1_stb : req0_stb;
  assign rack_g = grant_q ? res1_ack : res0_ack;
  assign a_g    = grant_q ? req1_a   : req0_a;
  assign b_g    = grant_q ? req1_b   : req0_b;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    rstb_d  = rstb_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    addb_d  = addb_q;
    astb_d  = astb_q;
    bstb_d  = bstb_q;
    zack_d  = zack_q;
    unique case (state_q)
      IDLE: begin
        if (req0_stb | req1_stb) begin
          grant_d        = winner;
          ack_d[winner]  = 1'b1;
          state_d        = ACCEPT;
        end
      end
      ACCEPT: begin
        // A dropped stb just leaves ack up.
        if (stb_g & ack_q[grant_q]) begin
          ack_d   = 2'b00;
          opa_d   = a_g;
          opb_d   = b_g;
          astb_d  = 1'b1;
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        if (astb_q & add_a_ack) begin
          astb_d  = 1'b0;
          addb_d  = opb_q;
          bstb_d  = 1'b1;
          state_d = SEND_B;
        end
      end
      SEND_B: begin
        if (bstb_q & add_b_ack) begin
          bstb_d  = 1'b0;
          zack_d  = 1'b1;
          state_d = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (add_z_stb & zack_q) begin
          zack_d = 1'b0;
          if (grant_q) res1_d = add_z;
          else         res0_d = add_z;
          rstb_d[grant_q] = 1'b1;
          state_d = RETURN;
        end
      end
      RETURN: begin
        if (rstb_q[grant_q] & rack_g) begin
          rstb_d[grant_q] = 1'b0;
          prio_d  = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      ack_q   <= 2'b00;
      rstb_q  <= 2'b00;
      res0_q  <= '0;
      res1_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      addb_q  <= '0;
      astb_q  <= 1'b0;
      bstb_q  <= 1'b0;
      zack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rstb_q  <= rstb_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      addb_q  <= addb_d;
      astb_q  <= astb_d;
      bstb_q  <= bstb_d;
      zack_q  <= zack_d;
    end
  end

  assign req0_ack  = ack_q[0];
  assign req1_ack  = ack_q[1];
  assign res0_stb  = rstb_q[0];
  assign res1_stb  = rstb_q[1];
  assign res0_z    = res0_q;
  assign res1_z    = res1_q;
  assign add_a     = opa_q;
  assign add_b     = addb_q;
  assign add_a_stb = astb_q;
  assign add_b_stb = bstb_q;
  assign add_z_ack = zack_q;
  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised bench for adder_arbiter with a transaction-level model.
// Drives two requesters, a behavioural float adder and result sinks.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0;
  logic [31:0] req1_a = '0, req1_b = '0;
  logic        req0_stb = 1'b0, req1_stb = 1'b0;
  logic        req0_ack, req1_ack;
  logic [31:0] res0_z, res1_z;
  logic        res0_stb, res1_stb;
  logic        res0_ack, res1_ack;
  logic [31:0] add_a, add_b;
  logic        add_a_stb, add_b_stb;
  logic        add_a_ack, add_b_ack;
  logic [31:0] add_z;
  logic        add_z_stb, add_z_ack;
  logic        busy, grant;

  adder_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_a(req0_a), .req0_b(req0_b),
    .req0_stb(req0_stb), .req0_ack(req0_ack),
    .req1_a(req1_a), .req1_b(req1_b),
    .req1_stb(req1_stb), .req1_ack(req1_ack),
    .res0_z(res0_z), .res0_stb(res0_stb),
    .res0_ack(res0_ack),
    .res1_z(res1_z), .res1_stb(res1_stb),
    .res1_ack(res1_ack),
    .add_a(add_a), .add_a_stb(add_a_stb),
    .add_a_ack(add_a_ack),
    .add_b(add_b), .add_b_stb(add_b_stb),
    .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb),
    .add_z_ack(add_z_ack),
    .busy(busy), .grant(grant)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single <-> double conversion, exact for the integer-valued operands used.
  function automatic real f2r(logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] itof(int n);
    return r2f(real'(n));
  endfunction

  function automatic logic [31:0] rnd_op();
    return itof(int'($urandom_range(0, 1000)));
  endfunction

  int a_delay = 0;
  int z_delay = 1;
  int hold0 = 0;
  int hold1 = 0;

  // Behavioural shared adder.
  initial begin
    int ph;
    int cnt;
    logic [31:0] ca, cb;
    ph = 0; cnt = 0; ca = '0; cb = '0;
    add_a_ack = 1'b0; add_b_ack = 1'b0;
    add_z_stb = 1'b0; add_z = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ph = 0; cnt = 0;
        add_a_ack = 1'b0; add_b_ack = 1'b0;
        add_z_stb = 1'b0;
      end else begin
        case (ph)
          0: if (add_a_stb) begin
            if (cnt >= a_delay) begin
              add_a_ack = 1'b1; ca = add_a; ph = 1; cnt = 0;
            end else cnt++;
          end
          1: begin add_a_ack = 1'b0; ph = 2; end
          2: if (add_b_stb) begin
            add_b_ack = 1'b1; cb = add_b; ph = 3;
          end
          3: begin
            add_b_ack = 1'b0;
            if (cnt >= z_delay) begin
              add_z = fadd(ca, cb); add_z_stb = 1'b1;
              ph = 4; cnt = 0;
            end else cnt++;
          end
          default: begin
            add_z_stb = 1'b0; add_z = 32'hDEADBEEF; ph = 0;
          end
        endcase
      end
    end
  end

  // Result sinks with programmable backpressure.
  initial begin
    int c0, c1;
    c0 = 0; c1 = 0;
    res0_ack = 1'b0; res1_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (res0_stb && rst) begin
        if (c0 >= hold0) res0_ack = 1'b1; else c0++;
      end else begin res0_ack = 1'b0; c0 = 0; end
      if (res1_stb && rst) begin
        if (c1 >= hold1) res1_ack = 1'b1; else c1++;
      end else begin res1_ack = 1'b0; c1 = 0; end
    end
  end

  // Transaction model: one op in flight, described by who owns it
  // and which handshake it is waiting on.
  bit          m_busy = 1'b0;
  bit          m_g = 1'b0;
  bit          m_prio = 1'b0;
  int          m_step = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [31:0] m_rz [2];
  int          deliv = 0;
  int          glog[$];

  initial begin
    m_rz[0] = '0; m_rz[1] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        m_busy = 1'b0; m_g = 1'b0; m_prio = 1'b0; m_step = 0;
        m_rz[0] = '0; m_rz[1] = '0;
      end else if (!m_busy) begin
        if (req0_stb || req1_stb) begin
          m_g = (req0_stb && req1_stb) ? m_prio : req1_stb;
          m_busy = 1'b1; m_step = 0;
          glog.push_back(int'(m_g));
        end
      end else begin
        case (m_step)
          0: if (m_g ? req1_stb : req0_stb) begin
            m_a = m_g ? req1_a : req0_a;
            m_b = m_g ? req1_b : req0_b;
            m_step = 1;
          end
          1: if (add_a_ack) m_step = 2;
          2: if (add_b_ack) m_step = 3;
          3: if (add_z_stb) begin
            m_rz[m_g] = fadd(m_a, m_b); m_step = 4;
          end
          default: if (m_g ? res1_ack : res0_ack) begin
            m_busy = 1'b0; m_prio = !m_g; deliv++;
          end
        endcase
      end
      chk1("busy", busy, m_busy);
      chk1("grant", grant, m_g);
      chk1("req0_ack", req0_ack, m_busy && m_step == 0 && !m_g);
      chk1("req1_ack", req1_ack, m_busy && m_step == 0 && m_g);
      chk1("add_a_stb", add_a_stb, m_busy && m_step == 1);
      chk1("add_b_stb", add_b_stb, m_busy && m_step == 2);
      chk1("add_z_ack", add_z_ack, m_busy && m_step == 3);
      chk1("res0_stb", res0_stb, m_busy && m_step == 4 && !m_g);
      chk1("res1_stb", res1_stb, m_busy && m_step == 4 && m_g);
      chk32("res0_z", res0_z, m_rz[0]);
      chk32("res1_z", res1_z, m_rz[1]);
      if (m_busy && m_step == 1) chk32("add_a", add_a, m_a);
      if (m_busy && m_step == 2) chk32("add_b", add_b, m_b);
    end
  end

  task automatic do_req(input bit who, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    n = 0;
    if (who) begin req1_a = a; req1_b = b; req1_stb = 1'b1; end
    else     begin req0_a = a; req0_b = b; req0_stb = 1'b1; end
    forever begin
      @(negedge clk);
      if ((who ? req1_ack : req0_ack) === 1'b1) break;
      n++;
      if (n > 400) begin
        n_cmp++; n_bad++;
        $display("FAIL req%0d_ack timeout: got no ack want ack", who);
        break;
      end
    end
    @(negedge clk);
    if (who) begin req1_stb = 1'b0; req1_a = '1; req1_b = '1; end
    else     begin req0_stb = 1'b0; req0_a = '1; req0_b = '1; end
  endtask

  task automatic wait_deliv(input int target);
    int n;
    n = 0;
    while (deliv < target) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL deliver timeout: got %0d want %0d", deliv, target);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_log(string nm, input int exp[$]);
    chk32({nm, "_len"}, 32'(glog.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < glog.size(); k++)
      chk32(nm, 32'(glog[k]), 32'(exp[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    chk32("lit_fadd", fadd(32'h3F800000, 32'h40000000), 32'h40400000);
    chk32("lit_itof", itof(12), 32'h41400000);

    // Single op.
    base = deliv;
    do_req(1'b0, 32'h3F800000, 32'h40000000);
    wait_deliv(base + 1);
    chk32("single_res0_z", res0_z, 32'h40400000);
    chk1("single_busy", busy, 1'b0);

    // Contention straight after reset.
    reset_pulse();
    glog.delete();
    base = deliv;
    fork
      do_req(1'b0, itof(10), itof(20));
      do_req(1'b1, itof(3), itof(4));
    join
    wait_deliv(base + 2);
    chk_log("contend_grant", '{0, 1});
    chk32("contend_res0_z", res0_z, 32'h41F00000);
    chk32("contend_res1_z", res1_z, 32'h40E00000);

    // Fairness with both always requesting.
    glog.delete();
    base = deliv;
    fork
      for (int k = 0; k < 4; k++) do_req(1'b0, rnd_op(), rnd_op());
      for (int k = 0; k < 4; k++) do_req(1'b1, rnd_op(), rnd_op());
    join
    wait_deliv(base + 8);
    chk_log("fair_grant", '{0, 1, 0, 1, 0, 1, 0, 1});

    // Result backpressure on requester 1.
    glog.delete();
    hold1 = 10;
    base = deliv;
    fork
      do_req(1'b1, itof(100), itof(200));
      begin
        repeat (2) @(negedge clk);
        do_req(1'b0, itof(1), itof(2));
      end
    join
    wait_deliv(base + 2);
    hold1 = 0;
    chk_log("bp_grant", '{1, 0});
    chk32("bp_res1_z", res1_z, itof(300));

    // Stalled adder operand port.
    a_delay = 5;
    base = deliv;
    do_req(1'b0, itof(40), itof(2));
    wait_deliv(base + 1);
    a_delay = 0;
    chk32("stall_res0_z", res0_z, itof(42));

    // Random traffic.
    base = deliv;
    fork
      for (int k = 0; k < 12; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        hold0 = int'($urandom_range(0, 3));
        a_delay = int'($urandom_range(0, 3));
        z_delay = int'($urandom_range(0, 4));
        do_req(1'b0, rnd_op(), rnd_op());
      end
      for (int k = 0; k < 12; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        hold1 = int'($urandom_range(0, 3));
        do_req(1'b1, rnd_op(), rnd_op());
      end
    join
    wait_deliv(base + 24);
    hold0 = 0; hold1 = 0; a_delay = 0;

    // Reset while waiting on the adder result.
    z_delay = 30;
    base = deliv;
    do_req(1'b0, itof(9), itof(9));
    n = 0;
    while (!(m_busy && m_step == 3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("waitz_reached", m_busy && m_step == 3, 1'b1);
    reset_pulse();
    chk32("rst_deliv", 32'(deliv), 32'(base));
    chk32("rst_res0_z", res0_z, 32'h0);
    z_delay = 1;
    base = deliv;
    do_req(1'b0, itof(7), itof(5));
    wait_deliv(base + 1);
    chk32("fresh_res0_z", res0_z, 32'h41400000);
    chk1("fresh_busy", busy, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
